alu_sequencer: RTL and testbench

//   Multi-cycle controller that sequences the 8-bit ALU for the execute stage.

---
 rtl/alu_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Four-state controller that runs one register-to-register command through the external ALU.
// Optional status flags (flag_z, flag_c) are built only when ALU_SEQ_FLAGS_EN is defined.
module alu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [1:0] cmd_dst,
    input  logic [1:0] cmd_src_a,
    input  logic [1:0] cmd_src_b,
    input  logic [7:0] cmd_imm,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_sum,
    output logic       done,
    output logic       err,
    output logic [7:0] result,
    input  logic [1:0] rd_addr,
    output logic [7:0] rd_data
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic       flag_z,
    output logic       flag_c
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

    localparam logic [3:0] OP_LDI = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [1:0] dst_q, dst_d, src_a_q, src_a_d, src_b_q, src_b_d;
    logic [7:0] imm_q, imm_d, res_q, res_d, result_q, result_d;
    logic [7:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0] alu_op_q, alu_op_d;
    logic       done_q, done_d, err_q, err_d;
    logic [7:0] regs_q [4];
    logic [7:0] regs_d [4];
    logic       illegal, uses_alu;
`ifdef ALU_SEQ_FLAGS_EN
    logic       carry_q, carry_d, flag_z_q, flag_z_d, flag_c_q, flag_c_d;
    logic [8:0] sum9;
`else
    // Flagless build: only the regfile and result are architectural state.
`endif

    assign illegal  = (op_q > 4'd6);
    assign uses_alu = (op_q != OP_LDI) && !illegal;
`ifdef ALU_SEQ_FLAGS_EN
    assign sum9     = {1'b0, alu_a_q} + {1'b0, alu_b_q};
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dst_d    = dst_q;
        src_a_d  = src_a_q;
        src_b_d  = src_b_q;
        imm_d    = imm_q;
        res_d    = res_q;
        result_d = result_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = 4'b0000;
        done_d   = 1'b0;
        err_d    = 1'b0;
        regs_d   = regs_q;
`ifdef ALU_SEQ_FLAGS_EN
        carry_d  = carry_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d    = cmd_op;
                    dst_d   = cmd_dst;
                    src_a_d = cmd_src_a;
                    src_b_d = cmd_src_b;
                    imm_d   = cmd_imm;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // The ALU operand registers double as the operand latches; LDI and
                // illegal ops leave them (and the ALU) untouched.
                if (uses_alu) begin
                    alu_a_d  = regs_q[src_a_q];
                    alu_b_d  = regs_q[src_b_q];
                    alu_op_d = op_q;
                end
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (op_q == OP_LDI) begin
                    res_d = imm_q;
                end else if (uses_alu) begin
                    res_d = alu_sum;
                end
`ifdef ALU_SEQ_FLAGS_EN
                case (op_q)
                    OP_ADD:  carry_d = sum9[8];
                    OP_SUB:  carry_d = (alu_a_q < alu_b_q);
                    default: carry_d = 1'b0;
                endcase
`endif
                done_d  = 1'b1;
                err_d   = illegal;
                state_d = S_WB;
            end
            S_WB: begin
                if (!err_q) begin
                    regs_d[dst_q] = res_q;
                    result_d      = res_q;
`ifdef ALU_SEQ_FLAGS_EN
                    flag_z_d      = (res_q == 8'h00);
                    flag_c_d      = carry_q;
`endif
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= 4'b0000;
            dst_q    <= 2'b00;
            src_a_q  <= 2'b00;
            src_b_q  <= 2'b00;
            imm_q    <= 8'h00;
            res_q    <= 8'h00;
            result_q <= 8'h00;
            alu_a_q  <= 8'h00;
            alu_b_q  <= 8'h00;
            alu_op_q <= 4'b0000;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < 4; i++) regs_q[i] <= 8'h00;
`ifdef ALU_SEQ_FLAGS_EN
            carry_q  <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            src_a_q  <= src_a_d;
            src_b_q  <= src_b_d;
            imm_q    <= imm_d;
            res_q    <= res_d;
            result_q <= result_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            done_q   <= done_d;
            err_q    <= err_d;
            for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
`ifdef ALU_SEQ_FLAGS_EN
            carry_q  <= carry_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
`endif
        end
    end

    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign done      = done_q;
    assign err       = err_q;
    assign result    = result_q;
    assign rd_data   = regs_q[rd_addr];
`ifdef ALU_SEQ_FLAGS_EN
    assign flag_z    = flag_z_q;
    assign flag_c    = flag_c_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: stimulus pushes expected completions, a monitor pops them on done.
// Flag checks are compiled in when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_sequencer;

    localparam int W = 13;  // {err, dst[1:0], res[7:0], z, c}

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [1:0] cmd_dst, cmd_src_a, cmd_src_b;
    logic [7:0] cmd_imm;
    logic [7:0] alu_a, alu_b, alu_sum;
    logic [3:0] alu_op;
    logic       done, err;
    logic [7:0] result, rd_data;
    logic [1:0] rd_addr;
`ifdef ALU_SEQ_FLAGS_EN
    logic       flag_z, flag_c;
`endif

    int n_vec  = 0;
    int n_fail = 0;
    int n_done = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    logic [7:0]   last_res = 8'h00;
    logic         last_z = 1'b0;
    logic         last_c = 1'b0;

    alu_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
        .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sum(alu_sum),
        .done(done), .err(err), .result(result),
        .rd_addr(rd_addr), .rd_data(rd_data)
`ifdef ALU_SEQ_FLAGS_EN
        , .flag_z(flag_z), .flag_c(flag_c)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    // Stand-in for the external combinational ALU
    always_comb begin
        case (alu_op)
            4'b0001: alu_sum = alu_a + alu_b;
            4'b0010: alu_sum = alu_a - alu_b;
            4'b0011: alu_sum = alu_a | alu_b;
            4'b0100: alu_sum = alu_a & alu_b;
            4'b0101: alu_sum = alu_a ^ alu_b;
            4'b0110: alu_sum = ~alu_a;
            default: alu_sum = 8'h00;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (err && !done) check("err_without_done", {31'd0, err}, 32'd0);
            if (done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("err", {31'd0, err}, {31'd0, mon_e[12]});
                    rd_addr = mon_e[11:10];
                    @(negedge clk);
                    check("done_pulse", {31'd0, done}, 32'd0);
                    if (!mon_e[12]) begin
                        check("result", {24'd0, result}, {24'd0, mon_e[9:2]});
                        check("wb_rd_data", {24'd0, rd_data}, {24'd0, mon_e[9:2]});
                        last_res = mon_e[9:2];
                        last_z   = mon_e[1];
                        last_c   = mon_e[0];
                    end else begin
                        check("result_held", {24'd0, result}, {24'd0, last_res});
                    end
`ifdef ALU_SEQ_FLAGS_EN
                    check("flag_z", {31'd0, flag_z}, {31'd0, last_z});
                    check("flag_c", {31'd0, flag_c}, {31'd0, last_c});
`endif
                end
            end
        end
    end

    // Driver: issue one command, push its expectation, check the 4-cycle timing
    task automatic issue(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb, input logic [7:0] imm, input logic [7:0] res,
                         input logic ez, input logic ec, input bit hold);
        int cnt;
        logic [3:0] exp_aop;
        logic is_err;
        is_err  = (op > 4'd6);
        exp_aop = (op >= 4'd1 && op <= 4'd6) ? op : 4'd0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = op; cmd_dst = dst; cmd_src_a = sa; cmd_src_b = sb; cmd_imm = imm;
        cnt = 0;
        while (!cmd_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("accept", {31'd0, cmd_ready}, 32'd1);
        exp_q.push_back({is_err, dst, res, ez, ec});
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (!hold || k == 4) cmd_valid = 1'b0;
            check("busy_ready", {31'd0, cmd_ready}, (k == 4) ? 32'd1 : 32'd0);
            check("alu_op_timing", {28'd0, alu_op}, (k == 2) ? {28'd0, exp_aop} : 32'd0);
            check("done_timing", {31'd0, done}, (k == 3) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic read_reg(input logic [1:0] addr, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = addr;
        #1;
        check("rd_data", {24'd0, rd_data}, {24'd0, exp});
    endtask

    int done_before;

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 4'd0; cmd_dst = 2'd0; cmd_src_a = 2'd0; cmd_src_b = 2'd0; cmd_imm = 8'h00;
        rd_addr = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_result", {24'd0, result}, 32'd0);
        check("reset_alu_op", {28'd0, alu_op}, 32'd0);
        check("reset_alu_a", {24'd0, alu_a}, 32'd0);
        check("reset_alu_b", {24'd0, alu_b}, 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
        check("reset_flag_z", {31'd0, flag_z}, 32'd0);
        check("reset_flag_c", {31'd0, flag_c}, 32'd0);
`endif
        for (int a = 0; a < 4; a++) read_reg(a[1:0], 8'h00);

        // LDI / ALU ops, hand-computed results and flags
        issue(4'b0000, 2'd1, 2'd0, 2'd0, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0);
        issue(4'b0000, 2'd1, 2'd0, 2'd0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
        issue(4'b0000, 2'd2, 2'd0, 2'd0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
        issue(4'b0001, 2'd3, 2'd1, 2'd2, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);  // FF+01
        issue(4'b0010, 2'd0, 2'd0, 2'd2, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);  // 00-01, dst==src
        issue(4'b0100, 2'd3, 2'd1, 2'd2, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);  // FF&01
        issue(4'b0101, 2'd3, 2'd0, 2'd2, 8'h00, 8'hFE, 1'b0, 1'b0, 1'b0);  // FF^01
        issue(4'b0011, 2'd3, 2'd2, 2'd3, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);  // 01|FE
        issue(4'b0010, 2'd3, 2'd2, 2'd2, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);  // 01-01
        issue(4'b0001, 2'd3, 2'd2, 2'd2, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0);  // 01+01
        issue(4'b0110, 2'd3, 2'd2, 2'd3, 8'h00, 8'hFE, 1'b0, 1'b0, 1'b0);  // ~01

        // Illegal opcodes: err with done, nothing written
        issue(4'b1010, 2'd0, 2'd1, 2'd2, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0);
        issue(4'b0111, 2'd1, 2'd2, 2'd3, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0);
        issue(4'b1111, 2'd2, 2'd0, 2'd1, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0);
        read_reg(2'd0, 8'hFF);
        read_reg(2'd1, 8'hFF);
        read_reg(2'd2, 8'h01);
        read_reg(2'd3, 8'hFE);
        check("illegal_result_held", {24'd0, result}, 32'h0000_00FE);

        // cmd_valid held through the busy window: exactly one execution
        done_before = n_done;
        issue(4'b0000, 2'd1, 2'd0, 2'd0, 8'h05, 8'h05, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        check("held_valid_one_done", n_done - done_before, 32'd1);

        // Reset during EXEC of ADD r1=r1+r1 aborts the command
        done_before = n_done;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 4'b0001; cmd_dst = 2'd1; cmd_src_a = 2'd1; cmd_src_b = 2'd1;
        check("abort_accept_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("abort_exec_alu_op", {28'd0, alu_op}, 32'd1);
        rst = 1'b1;
        last_res = 8'h00; last_z = 1'b0; last_c = 1'b0;
        @(negedge clk);
        check("ready_in_reset", {31'd0, cmd_ready}, 32'd0);
        check("abort_no_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
        check("abort_result", {24'd0, result}, 32'd0);
        check("abort_alu_a", {24'd0, alu_a}, 32'd0);
        check("abort_alu_b", {24'd0, alu_b}, 32'd0);
        check("abort_alu_op", {28'd0, alu_op}, 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
        check("abort_flag_z", {31'd0, flag_z}, 32'd0);
        check("abort_flag_c", {31'd0, flag_c}, 32'd0);
`endif
        for (int a = 0; a < 4; a++) read_reg(a[1:0], 8'h00);
        repeat (6) @(negedge clk);
        check("abort_done_count", n_done - done_before, 32'd0);

        // Normal operation resumes after reset
        issue(4'b0000, 2'd2, 2'd0, 2'd0, 8'h77, 8'h77, 1'b0, 1'b0, 1'b0);
        read_reg(2'd2, 8'h77);
        read_reg(2'd1, 8'h00);
        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

endmodule
